// File: rtl/trdb_pkg.sv
// Shared trace-debugger constants and the filter configuration encodings
// used by the multi-slot qualification filter.
package trdb_pkg;

  localparam int unsigned XLEN            = 32;
  localparam int unsigned CAUSE_LEN       = 5;
  localparam int unsigned PRIV_LEN        = 2;
  localparam int unsigned DEFAULT_NUM_CMP = 4;

  typedef enum logic [2:0] {
    SRC_CAUSE = 3'd0,
    SRC_TVEC  = 3'd1,
    SRC_TVAL  = 3'd2,
    SRC_PRIV  = 3'd3,
    SRC_IADDR = 3'd4
  } filter_src_e;

  typedef enum logic [1:0] {
    MODE_EQ    = 2'd0,
    MODE_RANGE = 2'd1,
    MODE_NE    = 2'd2,
    MODE_OUT   = 2'd3
  } filter_mode_e;

  typedef enum logic [1:0] {
    ACT_QUALIFY     = 2'd0,
    ACT_START       = 2'd1,
    ACT_STOP        = 2'd2,
    ACT_QUALIFY_ALT = 2'd3
  } filter_action_e;

  typedef enum logic {
    WIN_OFF = 1'b0,
    WIN_ON  = 1'b1
  } win_state_e;

endpackage

// File: rtl/trdb_multi_filter_if.sv
// Retirement-side bundle feeding the trace filter: one retired instruction
// per cycle when valid_i is high.
interface trdb_multi_filter_if #(
  parameter int unsigned XLEN      = trdb_pkg::XLEN,
  parameter int unsigned CAUSE_LEN = trdb_pkg::CAUSE_LEN,
  parameter int unsigned PRIV_LEN  = trdb_pkg::PRIV_LEN
);

  logic                 valid_i;
  logic [CAUSE_LEN-1:0] cause_i;
  logic [XLEN-1:2]      tvec_i;
  logic [XLEN-1:0]      tval_i;
  logic [PRIV_LEN-1:0]  priv_lvl_i;
  logic [XLEN-1:0]      iaddr_i;

  modport master (output valid_i, cause_i, tvec_i, tval_i, priv_lvl_i, iaddr_i);
  modport slave  (input  valid_i, cause_i, tvec_i, tval_i, priv_lvl_i, iaddr_i);

endinterface

// File: rtl/trdb_filter_cmp.sv
// One comparator slot: picks an operand, zero-extends it to XLEN and applies
// the selected unsigned compare. Purely combinational.
module trdb_filter_cmp #(
  parameter int unsigned XLEN = trdb_pkg::XLEN
) (
  input  logic                          en,
  input  logic [2:0]                    src,
  input  logic [1:0]                    mode,
  input  logic [XLEN-1:0]               lower,
  input  logic [XLEN-1:0]               upper,
  input  logic [trdb_pkg::CAUSE_LEN-1:0] cause,
  input  logic [XLEN-1:2]               tvec,
  input  logic [XLEN-1:0]               tval,
  input  logic [trdb_pkg::PRIV_LEN-1:0]  priv_lvl,
  input  logic [XLEN-1:0]               iaddr,
  output logic                          active,
  output logic                          match
);
  import trdb_pkg::*;

  logic [XLEN-1:0] op;
  logic            src_ok;
  logic            eq;
  logic            in_rng;
  logic            raw;

  always_comb begin
    // NOTE: defaults first so every path assigns op/src_ok and no latch is inferred.
    op     = '0;
    src_ok = 1'b1;
    case (src)
      SRC_CAUSE: op = XLEN'(cause);
      SRC_TVEC:  op = {tvec, 2'b00};
      SRC_TVAL:  op = tval;
      SRC_PRIV:  op = XLEN'(priv_lvl);
      SRC_IADDR: op = iaddr;
      default:   src_ok = 1'b0;
    endcase
  end

  // With lower > upper in_rng can never be true, so range never matches and
  // out-of-range always does, without a special case.
  assign eq     = (op == lower);
  assign in_rng = (op >= lower) && (op <= upper);

  always_comb begin
    raw = 1'b0;
    case (mode)
      MODE_EQ:    raw = eq;
      MODE_RANGE: raw = in_rng;
      MODE_NE:    raw = !eq;
      default:    raw = !in_rng;
    endcase
  end

  assign active = en && src_ok;
  assign match  = active && raw;

endmodule

// File: rtl/trdb_multi_filter.sv
// Instruction-trace qualification filter: NUM_CMP comparator slots acting as
// qualifiers or start/stop triggers of a trace window, with registered outputs.
module trdb_multi_filter #(
  parameter int unsigned NUM_CMP = trdb_pkg::DEFAULT_NUM_CMP,
  parameter int unsigned XLEN    = trdb_pkg::XLEN,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  trdb_multi_filter_if.slave      ret,
  input  logic [NUM_CMP-1:0]      cmp_en_i,
  input  logic [NUM_CMP*3-1:0]    cmp_src_i,
  input  logic [NUM_CMP*2-1:0]    cmp_mode_i,
  input  logic [NUM_CMP*2-1:0]    cmp_action_i,
  input  logic [NUM_CMP*XLEN-1:0] cmp_lower_i,
  input  logic [NUM_CMP*XLEN-1:0] cmp_upper_i,
  input  logic                    clear_i,
  output logic                    qualified_o,
  output logic [NUM_CMP-1:0]      match_o,
  output logic                    window_o,
  output logic [CNT_W-1:0]        qual_cnt_o
);
  import trdb_pkg::*;

  logic [NUM_CMP-1:0] slot_active;
  logic [NUM_CMP-1:0] slot_match;
  logic [NUM_CMP-1:0] is_start;
  logic [NUM_CMP-1:0] is_stop;
  logic [NUM_CMP-1:0] is_qual;

  for (genvar i = 0; i < NUM_CMP; i++) begin : g_slot
    trdb_filter_cmp #(.XLEN(XLEN)) u_cmp (
      .en       (cmp_en_i[i]),
      .src      (cmp_src_i[3*i +: 3]),
      .mode     (cmp_mode_i[2*i +: 2]),
      .lower    (cmp_lower_i[XLEN*i +: XLEN]),
      .upper    (cmp_upper_i[XLEN*i +: XLEN]),
      .cause    (ret.cause_i),
      .tvec     (ret.tvec_i),
      .tval     (ret.tval_i),
      .priv_lvl (ret.priv_lvl_i),
      .iaddr    (ret.iaddr_i),
      .active   (slot_active[i]),
      .match    (slot_match[i])
    );

    assign is_start[i] = (cmp_action_i[2*i +: 2] == ACT_START);
    assign is_stop[i]  = (cmp_action_i[2*i +: 2] == ACT_STOP);
    assign is_qual[i]  = !is_start[i] && !is_stop[i];
  end

  logic       qual_term;
  logic       start_en;
  logic       start_hit;
  logic       stop_hit;
  logic       win_eff;
  logic       qual_now;
  win_state_e state;
  win_state_e idle_state;

  // Inactive qualify slots contribute a 1, so no qualifier means "qualify all".
  assign qual_term  = &(~(slot_active & is_qual) | slot_match);
  assign start_en   = |(slot_active & is_start);
  assign start_hit  = |(slot_match & is_start);
  assign stop_hit   = |(slot_match & is_stop);
  assign idle_state = start_en ? WIN_OFF : WIN_ON;

  // The start instruction joins the window; a stop instruction is covered
  // because the state is still ON while it is evaluated.
  assign win_eff  = (state == WIN_ON) || start_hit;
  assign qual_now = ret.valid_i && win_eff && qual_term;

  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
    if (!rst_ni || clear_i) begin
      state       <= idle_state;
      qualified_o <= 1'b0;
      match_o     <= '0;
      qual_cnt_o  <= '0;
    end else begin
      qualified_o <= qual_now;
      match_o     <= ret.valid_i ? slot_match : '0;
      if (qual_now && (qual_cnt_o != '1)) qual_cnt_o <= qual_cnt_o + CNT_W'(1);

      if (ret.valid_i && stop_hit)       state <= WIN_OFF;
      else if (ret.valid_i && start_hit) state <= WIN_ON;
      else if (!start_en)                state <= WIN_ON;
    end
  end

  assign window_o = (state == WIN_ON);

endmodule
